// File: rtl/hist_pkg.sv
// Shared types and arithmetic for the histogram accumulator.
// Forward entries are held at a fixed maximum width, so instances need BINS <= 2^16 and CNT_W <= 64.
package hist_pkg;
    localparam int unsigned HIST_MAX_AW    = 16;
    localparam int unsigned HIST_MAX_CNT_W = 64;

    typedef enum logic [1:0] {IDLE, DRAIN, SWEEP} state_t;

    typedef struct packed {
        logic                      valid;
        logic [HIST_MAX_AW-1:0]    bin;
        logic [HIST_MAX_CNT_W-1:0] value;
    } fwd_entry_t;

    function automatic logic hist_add_carry(input logic [HIST_MAX_CNT_W-1:0] old,
                                            input logic [HIST_MAX_CNT_W-1:0] wt,
                                            input logic [6:0]                cnt_w);
        logic [HIST_MAX_CNT_W:0] sum;
        sum = {1'b0, old} + {1'b0, wt};
        return sum[cnt_w];
    endfunction

    // Operands must already fit in cnt_w bits; a carry out of bit cnt_w-1 clamps or wraps.
    function automatic logic [HIST_MAX_CNT_W-1:0] hist_sat_add(input logic [HIST_MAX_CNT_W-1:0] old,
                                                               input logic [HIST_MAX_CNT_W-1:0] wt,
                                                               input logic [6:0]                cnt_w,
                                                               input logic                      sat);
        logic [HIST_MAX_CNT_W:0]   sum;
        logic [HIST_MAX_CNT_W-1:0] ones;
        sum  = {1'b0, old} + {1'b0, wt};
        ones = (cnt_w >= 7'(HIST_MAX_CNT_W)) ? '1
             : ((HIST_MAX_CNT_W'(1) << cnt_w) - HIST_MAX_CNT_W'(1));
        if (sum[cnt_w]) return sat ? ones : (sum[HIST_MAX_CNT_W-1:0] & ones);
        return sum[HIST_MAX_CNT_W-1:0];
    endfunction
endpackage

// File: rtl/hist_sdp_ram.sv
// Simple-dual-port RAM with a two-cycle registered read; a read colliding with a write returns old data.
module hist_sdp_ram #(
    parameter int unsigned DEPTH = 32,
    parameter int unsigned WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [WIDTH-1:0]         wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [WIDTH-1:0]         rdata
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd_stage;

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rd_stage <= mem[raddr];
        rdata    <= rd_stage;
    end
endmodule

// File: rtl/hist_accum_ram.sv
// Pipelined weighted histogram accumulator (R -> B -> W) with write forwarding, readout slots and clear sweep.
//   state | meaning
//   IDLE  | accepting updates and readouts
//   DRAIN | two cycles letting in-flight updates retire
//   SWEEP | writing zero to one bin per cycle
module hist_accum_ram
    import hist_pkg::*;
#(
    parameter int unsigned BINS     = 32,
    parameter int unsigned CNT_W    = 32,
    parameter int unsigned WT_W     = 8,
    parameter bit          SATURATE = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [$clog2(BINS)-1:0] in_bin,
    input  logic [WT_W-1:0]         in_weight,
    input  logic                    rd_req,
    input  logic [$clog2(BINS)-1:0] rd_bin,
    output logic                    rd_valid,
    output logic [CNT_W-1:0]        rd_count,
    input  logic                    clr_start,
    output logic                    busy,
    output logic                    clr_done,
    output logic                    overflow
);
    localparam int unsigned AW = $clog2(BINS);

    state_t        state, state_nx;
    logic          drain_cnt, drain_cnt_nx;
    logic [AW-1:0] sweep_idx, sweep_idx_nx;
    logic          clr_acc;

    logic            r_upd, r_rd;
    logic            b_upd, b_rd, w_upd, w_rd;
    logic [AW-1:0]   b_bin, w_bin;
    logic [WT_W-1:0] b_wt, w_wt;

    fwd_entry_t                hist [2];
    logic [HIST_MAX_CNT_W-1:0] operand;
    logic                      carry;
    logic [CNT_W-1:0]          upd_value;

    logic             sweep_we, ram_we;
    logic [AW-1:0]    ram_waddr, ram_raddr;
    logic [CNT_W-1:0] ram_wdata, ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= SWEEP;
            sweep_idx <= '0;
            drain_cnt <= 1'b0;
        end else begin
            state     <= state_nx;
            sweep_idx <= sweep_idx_nx;
            drain_cnt <= drain_cnt_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        sweep_idx_nx = sweep_idx;
        drain_cnt_nx = drain_cnt;
        clr_acc      = 1'b0;
        clr_done     = 1'b0;
        case (state)
            IDLE: if (clr_start) begin
                clr_acc      = 1'b1;
                drain_cnt_nx = 1'b1;
                state_nx     = DRAIN;
            end
            DRAIN: if (drain_cnt == 1'b0) begin
                sweep_idx_nx = '0;
                state_nx     = SWEEP;
            end else begin
                drain_cnt_nx = drain_cnt - 1'b1;
            end
            SWEEP: if (sweep_idx == AW'(BINS - 1)) begin
                clr_done = 1'b1;
                state_nx = IDLE;
            end else begin
                sweep_idx_nx = sweep_idx + 1'b1;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy      = (state != IDLE);
    assign in_ready  = (state == IDLE) & ~rd_req;
    assign r_rd      = (state == IDLE) & rd_req;
    // Out-of-range bins are accepted but never become a write.
    assign r_upd     = in_valid & in_ready & (32'(in_bin) < BINS);
    assign ram_raddr = r_rd ? rd_bin : in_bin;

    always_ff @(posedge clk) begin
        if (rst) begin
            b_upd <= 1'b0;
            b_rd  <= 1'b0;
            w_upd <= 1'b0;
            w_rd  <= 1'b0;
        end else begin
            b_upd <= r_upd;
            b_rd  <= r_rd;
            w_upd <= b_upd;
            w_rd  <= b_rd;
        end
        b_bin <= ram_raddr;
        b_wt  <= in_weight;
        w_bin <= b_bin;
        w_wt  <= b_wt;
    end

    // Newest history entry wins; RAM data lags the last two writes.
    always_comb begin
        operand = HIST_MAX_CNT_W'(ram_rdata);
        if (hist[1].valid && hist[1].bin == HIST_MAX_AW'(w_bin)) operand = hist[1].value;
        if (hist[0].valid && hist[0].bin == HIST_MAX_AW'(w_bin)) operand = hist[0].value;
    end

    assign carry     = hist_add_carry(operand, HIST_MAX_CNT_W'(w_wt), 7'(CNT_W));
    assign upd_value = CNT_W'(hist_sat_add(operand, HIST_MAX_CNT_W'(w_wt), 7'(CNT_W), SATURATE));

    assign sweep_we  = (state == SWEEP);
    assign ram_we    = sweep_we | w_upd;
    assign ram_waddr = sweep_we ? sweep_idx : w_bin;
    assign ram_wdata = sweep_we ? '0 : upd_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            hist[0] <= '0;
            hist[1] <= '0;
        end else if (ram_we) begin
            hist[1] <= hist[0];
            hist[0] <= '{valid: 1'b1, bin: HIST_MAX_AW'(ram_waddr), value: HIST_MAX_CNT_W'(ram_wdata)};
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                overflow <= 1'b0;
        else if (clr_acc)       overflow <= 1'b0;
        else if (w_upd & carry) overflow <= 1'b1;
    end

    assign rd_valid = w_rd;
    assign rd_count = w_rd ? CNT_W'(operand) : '0;

    hist_sdp_ram #(.DEPTH(BINS), .WIDTH(CNT_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );
endmodule

// File: tb/tb_hist_accum_ram.sv
// Directed bench driving three accumulators in parallel: 32x32-bit saturating,
// and 24x8-bit in saturating and wrapping flavours.
module tb_hist_accum_ram;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, rd_req = 1'b0, clr_start = 1'b0;
    logic [4:0] in_bin = '0, rd_bin = '0;
    logic [7:0] in_weight = '0;

    logic a_in_ready, a_rd_valid, a_busy, a_clr_done, a_overflow;
    logic s_in_ready, s_rd_valid, s_busy, s_clr_done, s_overflow;
    logic w_in_ready, w_rd_valid, w_busy, w_clr_done, w_overflow;
    logic [31:0] a_rd_count;
    logic [7:0]  s_rd_count, w_rd_count;

    int n_tests = 0;
    int n_fail  = 0;

    logic        up_ready;
    logic        rq_ready, rq_early, rq_valid;
    logic [31:0] rq_a;
    logic [7:0]  rq_s, rq_w;

    hist_accum_ram #(.BINS(32), .CNT_W(32), .WT_W(8), .SATURATE(1'b1)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_in_ready), .in_bin(in_bin),
        .in_weight(in_weight), .rd_req(rd_req), .rd_bin(rd_bin), .rd_valid(a_rd_valid),
        .rd_count(a_rd_count), .clr_start(clr_start), .busy(a_busy), .clr_done(a_clr_done),
        .overflow(a_overflow)
    );
    hist_accum_ram #(.BINS(24), .CNT_W(8), .WT_W(8), .SATURATE(1'b1)) dut_s (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_bin(in_bin),
        .in_weight(in_weight), .rd_req(rd_req), .rd_bin(rd_bin), .rd_valid(s_rd_valid),
        .rd_count(s_rd_count), .clr_start(clr_start), .busy(s_busy), .clr_done(s_clr_done),
        .overflow(s_overflow)
    );
    hist_accum_ram #(.BINS(24), .CNT_W(8), .WT_W(8), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready), .in_bin(in_bin),
        .in_weight(in_weight), .rd_req(rd_req), .rd_bin(rd_bin), .rd_valid(w_rd_valid),
        .rd_count(w_rd_count), .clr_start(clr_start), .busy(w_busy), .clr_done(w_clr_done),
        .overflow(w_overflow)
    );

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_update(input logic [4:0] bin, input logic [7:0] wt);
        in_valid  = 1'b1;
        in_bin    = bin;
        in_weight = wt;
        @(negedge clk);
        up_ready = a_in_ready & s_in_ready & w_in_ready;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] bin);
        rd_req = 1'b1;
        rd_bin = bin;
        @(negedge clk);
        rq_ready = a_in_ready | s_in_ready | w_in_ready;
        step();
        rd_req = 1'b0;
        @(negedge clk);
        rq_early = a_rd_valid | s_rd_valid | w_rd_valid;
        step();
        @(negedge clk);
        rq_valid = a_rd_valid & s_rd_valid & w_rd_valid;
        rq_a = a_rd_count;
        rq_s = s_rd_count;
        rq_w = w_rd_count;
        step();
    endtask

    task automatic test_reset();
        int na = 0, ns = 0, ka = -1, ks = -1;
        logic busy31 = 1'b0, busy32 = 1'b1, ready32 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_tests++; if (a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b expected 0", a_in_ready); end
        n_tests++; if (a_busy !== 1'b1) begin n_fail++; $display("FAIL rst_busy: got %b expected 1", a_busy); end
        step();
        rst = 1'b0;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                n_tests++; if (a_rd_valid !== 1'b0 || a_rd_count !== 32'd0) begin n_fail++; $display("FAIL rst_rd: got valid %b count %0d expected 0 0", a_rd_valid, a_rd_count); end
                n_tests++; if (a_overflow !== 1'b0 || a_clr_done !== 1'b0) begin n_fail++; $display("FAIL rst_flags: got ovf %b done %b expected 0 0", a_overflow, a_clr_done); end
                n_tests++; if (a_busy !== 1'b1 || a_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_sweep: got busy %b ready %b expected 1 0", a_busy, a_in_ready); end
            end
            if (a_clr_done) begin na++; ka = k; end
            if (s_clr_done) begin ns++; ks = k; end
            if (k == 31) busy31 = a_busy;
            if (k == 32) begin busy32 = a_busy; ready32 = a_in_ready; end
            step();
        end
        n_tests++; if (na !== 1 || ka !== 31) begin n_fail++; $display("FAIL rst_done_a: got %0d pulses at cycle %0d expected 1 at 31", na, ka); end
        n_tests++; if (ns !== 1 || ks !== 23) begin n_fail++; $display("FAIL rst_done_s: got %0d pulses at cycle %0d expected 1 at 23", ns, ks); end
        n_tests++; if (busy31 !== 1'b1 || busy32 !== 1'b0 || ready32 !== 1'b1) begin n_fail++; $display("FAIL rst_release: got busy31 %b busy32 %b ready32 %b expected 1 0 1", busy31, busy32, ready32); end
        do_read(5'd0);
        n_tests++; if (rq_valid !== 1'b1 || rq_a !== 32'd0 || rq_s !== 8'd0 || rq_w !== 8'd0) begin n_fail++; $display("FAIL rst_bin0: got v%b %0d/%0d/%0d expected v1 0/0/0", rq_valid, rq_a, rq_s, rq_w); end
        do_read(5'd17);
        n_tests++; if (rq_valid !== 1'b1 || rq_a !== 32'd0 || rq_s !== 8'd0 || rq_w !== 8'd0) begin n_fail++; $display("FAIL rst_bin17: got v%b %0d/%0d/%0d expected v1 0/0/0", rq_valid, rq_a, rq_s, rq_w); end
        do_read(5'd31);
        n_tests++; if (a_rd_valid !== 1'b0 || rq_a !== 32'd0) begin n_fail++; $display("FAIL rst_bin31: got %0d expected 0", rq_a); end
    endtask

    task automatic test_saturate();
        logic ok = 1'b1;
        repeat (3) begin do_update(5'd1, 8'd100); ok &= up_ready; end
        do_read(5'd1);
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL sat_ready: got %b expected 1", ok); end
        n_tests++; if (rq_ready !== 1'b0) begin n_fail++; $display("FAIL sat_rdreq_ready: got %b expected 0", rq_ready); end
        n_tests++; if (rq_s !== 8'd255) begin n_fail++; $display("FAIL sat_clamp: got %0d expected 255", rq_s); end
        n_tests++; if (rq_w !== 8'd44) begin n_fail++; $display("FAIL sat_wrap: got %0d expected 44", rq_w); end
        n_tests++; if (rq_a !== 32'd300) begin n_fail++; $display("FAIL sat_wide: got %0d expected 300", rq_a); end
        n_tests++; if (s_overflow !== 1'b1 || w_overflow !== 1'b1 || a_overflow !== 1'b0) begin n_fail++; $display("FAIL sat_ovf: got s%b w%b a%b expected 1 1 0", s_overflow, w_overflow, a_overflow); end
    endtask

    task automatic test_weighted();
        logic ok = 1'b1;
        repeat (10) begin do_update(5'd5, 8'd1); ok &= up_ready; end
        do_read(5'd5);
        n_tests++; if (rq_a !== 32'd10 || rq_s !== 8'd10 || rq_w !== 8'd10) begin n_fail++; $display("FAIL wt1: got %0d/%0d/%0d expected 10/10/10", rq_a, rq_s, rq_w); end
        repeat (10) begin do_update(5'd6, 8'd200); ok &= up_ready; end
        do_read(5'd6);
        n_tests++; if (rq_a !== 32'd2000) begin n_fail++; $display("FAIL wt200_a: got %0d expected 2000", rq_a); end
        n_tests++; if (rq_s !== 8'd255 || rq_w !== 8'd208) begin n_fail++; $display("FAIL wt200_narrow: got %0d/%0d expected 255/208", rq_s, rq_w); end
        n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL wt_ready: got %b expected 1", ok); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 16; i++) do_update((i % 2 == 0) ? 5'd3 : 5'd4, 8'd1);
        do_read(5'd3);
        n_tests++; if (rq_early !== 1'b0) begin n_fail++; $display("FAIL b2b_early: got rd_valid %b at t+1 expected 0", rq_early); end
        n_tests++; if (rq_valid !== 1'b1 || rq_a !== 32'd8 || rq_s !== 8'd8 || rq_w !== 8'd8) begin n_fail++; $display("FAIL b2b_bin3: got v%b %0d/%0d/%0d expected v1 8/8/8", rq_valid, rq_a, rq_s, rq_w); end
        do_read(5'd4);
        n_tests++; if (rq_a !== 32'd8 || rq_s !== 8'd8 || rq_w !== 8'd8) begin n_fail++; $display("FAIL b2b_bin4: got %0d/%0d/%0d expected 8/8/8", rq_a, rq_s, rq_w); end
    endtask

    task automatic test_drop();
        do_update(5'd28, 8'd50);
        n_tests++; if (up_ready !== 1'b1) begin n_fail++; $display("FAIL drop_ready: got %b expected 1", up_ready); end
        do_read(5'd28);
        n_tests++; if (rq_a !== 32'd50) begin n_fail++; $display("FAIL drop_inrange_a: got %0d expected 50", rq_a); end
        do_read(5'd1);
        n_tests++; if (rq_s !== 8'd255 || rq_w !== 8'd44) begin n_fail++; $display("FAIL drop_bin1: got %0d/%0d expected 255/44", rq_s, rq_w); end
        do_read(5'd4);
        n_tests++; if (rq_s !== 8'd8 || rq_w !== 8'd8) begin n_fail++; $display("FAIL drop_bin4: got %0d/%0d expected 8/8", rq_s, rq_w); end
    endtask

    task automatic test_clear();
        int nd_a = 0, nd_s = 0, kd_a = -1, kd_s = -1;
        logic ok_ready = 1'b1, busy1 = 1'b0, ovf1 = 1'b1, ready35 = 1'b0;
        in_valid  = 1'b1;
        in_bin    = 5'd2;
        in_weight = 8'd3;
        repeat (3) step();
        clr_start = 1'b1;
        @(negedge clk);
        step();
        clr_start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            in_valid = (k <= 26);
            @(negedge clk);
            if (k == 1) begin busy1 = a_busy; ovf1 = a_overflow | s_overflow | w_overflow; end
            if (k <= 34 && a_in_ready) ok_ready = 1'b0;
            if (k <= 26 && (s_in_ready || w_in_ready)) ok_ready = 1'b0;
            if (k == 35) ready35 = a_in_ready;
            if (a_clr_done) begin nd_a++; kd_a = k; end
            if (s_clr_done) begin nd_s++; kd_s = k; end
            step();
        end
        n_tests++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL clr_busy: got %b expected 1", busy1); end
        n_tests++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_cleared: got %b expected 0", ovf1); end
        n_tests++; if (ok_ready !== 1'b1) begin n_fail++; $display("FAIL clr_ready_low: got %b expected 1", ok_ready); end
        n_tests++; if (nd_a !== 1 || kd_a !== 34) begin n_fail++; $display("FAIL clr_done_a: got %0d pulses at %0d expected 1 at 34", nd_a, kd_a); end
        n_tests++; if (nd_s !== 1 || kd_s !== 26) begin n_fail++; $display("FAIL clr_done_s: got %0d pulses at %0d expected 1 at 26", nd_s, kd_s); end
        n_tests++; if (ready35 !== 1'b1) begin n_fail++; $display("FAIL clr_ready_back: got %b expected 1", ready35); end
        for (int i = 0; i < 4; i++) begin
            do_read((i == 0) ? 5'd0 : (i == 1) ? 5'd2 : (i == 2) ? 5'd5 : 5'd1);
            n_tests++; if (rq_a !== 32'd0 || rq_s !== 8'd0 || rq_w !== 8'd0) begin n_fail++; $display("FAIL clr_zero_%0d: got %0d/%0d/%0d expected 0/0/0", i, rq_a, rq_s, rq_w); end
        end
        do_read(5'd31);
        n_tests++; if (rq_a !== 32'd0) begin n_fail++; $display("FAIL clr_zero_a31: got %0d expected 0", rq_a); end
        n_tests++; if (a_overflow !== 1'b0 || s_overflow !== 1'b0 || w_overflow !== 1'b0) begin n_fail++; $display("FAIL clr_ovf_after: got a%b s%b w%b expected 0 0 0", a_overflow, s_overflow, w_overflow); end
        do_update(5'd2, 8'd7);
        do_read(5'd2);
        n_tests++; if (rq_a !== 32'd7 || rq_s !== 8'd7 || rq_w !== 8'd7) begin n_fail++; $display("FAIL clr_post_update: got %0d/%0d/%0d expected 7/7/7", rq_a, rq_s, rq_w); end
    endtask

    initial begin
        test_reset();
        test_saturate();
        test_weighted();
        test_back_to_back();
        test_drop();
        test_clear();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
